tone_meter: RTL and testbench

Receive-side counterpart of the test-signal generators: consumes a stream of audio samples and measures the tone's period in samples and its per-period peak values. It detects rising zero crossings with hysteresis. It sits after the generator or the audio datapath under test, so signal integrity can be checked in hardware. One result is produced per completed period, and a no-signal condition is flagged when no crossing arrives within a bounded time.

---
 rtl/tone_meter.sv | 130 +++++++++++++
 tb/tb_tone_meter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_meter.sv
`default_nettype none
// ============================================================================
// tone_meter : measures tone period and per-period signed peaks from a stream
//              of audio samples using hysteresis-qualified rising crossings.
// Revision   : 1.0
// ============================================================================
module tone_meter #(
    parameter int DATA_WD   = 24,
    parameter bit SIGNED_IN = 1'b0,
    parameter int HYST      = 256,
    parameter int CNT_WD    = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [DATA_WD-1:0] sample_i,
    input  logic               sample_valid_i,
    output logic [CNT_WD-1:0]  period_o,
    output logic [DATA_WD-1:0] max_o,
    output logic [DATA_WD-1:0] min_o,
    output logic               meas_valid_o,
    output logic               locked_o,
    output logic               no_signal_o
);

    typedef enum logic [1:0] {
        SEEK_LOW  = 2'd0,
        SEEK_HIGH = 2'd1,
        MEAS_LOW  = 2'd2,
        MEAS_HIGH = 2'd3
    } state_t;

    localparam logic signed [DATA_WD-1:0] HYST_POS = DATA_WD'(HYST);
    localparam logic signed [DATA_WD-1:0] HYST_NEG = -HYST_POS;

    state_t                      state;
    state_t                      state_nxt;
    logic signed [DATA_WD-1:0]   s;
    logic signed [DATA_WD-1:0]   acc_max;
    logic signed [DATA_WD-1:0]   acc_min;
    logic        [CNT_WD-1:0]    cnt;
    logic                        is_low;
    logic                        is_high;
    logic                        first_cross;
    logic                        meas;
    logic                        timeout;

    // Offset binary becomes two's complement by flipping the MSB.
    assign s       = SIGNED_IN ? sample_i : {~sample_i[DATA_WD-1], sample_i[DATA_WD-2:0]};
    assign is_low  = (s <= HYST_NEG);
    assign is_high = (s >= HYST_POS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= SEEK_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        first_cross = 1'b0;
        meas        = 1'b0;
        timeout     = 1'b0;
        if (sample_valid_i) begin
            case (state)
                SEEK_LOW:  if (is_low) state_nxt = SEEK_HIGH;
                SEEK_HIGH: begin
                    if (is_high) begin
                        first_cross = 1'b1;
                        state_nxt   = MEAS_LOW;
                    end
                end
                MEAS_LOW:  if (is_low) state_nxt = MEAS_HIGH;
                MEAS_HIGH: begin
                    if (is_high) begin
                        meas      = 1'b1;
                        state_nxt = MEAS_LOW;
                    end
                end
                default:   state_nxt = SEEK_LOW;
            endcase
            // A saturated counter with no crossing on this sample means the tone is gone.
            if (!first_cross && !meas && (&cnt)) begin
                timeout   = 1'b1;
                state_nxt = SEEK_LOW;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt          <= '0;
            acc_max      <= '0;
            acc_min      <= '0;
            period_o     <= '0;
            max_o        <= '0;
            min_o        <= '0;
            meas_valid_o <= 1'b0;
            locked_o     <= 1'b0;
            no_signal_o  <= 1'b0;
        end else begin
            meas_valid_o <= meas;
            if (sample_valid_i) begin
                if (first_cross || meas) begin
                    cnt     <= '0;
                    acc_max <= s;
                    acc_min <= s;
                end else begin
                    cnt <= timeout ? '0 : cnt + 1'b1;
                    if (s > acc_max) acc_max <= s;
                    if (s < acc_min) acc_min <= s;
                end
                if (meas) begin
                    period_o    <= cnt + 1'b1;
                    max_o       <= acc_max;
                    min_o       <= acc_min;
                    locked_o    <= 1'b1;
                    no_signal_o <= 1'b0;
                end
                if (timeout) begin
                    locked_o    <= 1'b0;
                    no_signal_o <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_meter.sv
`default_nettype none
// ============================================================================
// tb_tone_meter : directed checks of tone_meter with triangle test tones.
// Revision      : 1.0
// ============================================================================
module tb_tone_meter;

    localparam int DW   = 24;
    localparam int CW   = 16;
    localparam int HY   = 256;
    localparam int STEP = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          sample_valid = 1'b0;
    logic [CW-1:0] period;
    logic [DW-1:0] max_v;
    logic [DW-1:0] min_v;
    logic          meas_valid;
    logic          locked;
    logic          no_signal;

    tone_meter #(
        .DATA_WD   (DW),
        .SIGNED_IN (1'b0),
        .HYST      (HY),
        .CNT_WD    (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .period_o       (period),
        .max_o          (max_v),
        .min_o          (min_v),
        .meas_valid_o   (meas_valid),
        .locked_o       (locked),
        .no_signal_o    (no_signal)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int q_per[$];
    int q_max[$];
    int q_min[$];
    int cyc      = 0;
    int last_cyc = 0;
    int gap      = 0;
    int wide     = 0;
    logic mv_d   = 1'b0;

    // Pulse recorder: captures every measurement and the spacing between pulses.
    always @(negedge clk) begin
        cyc++;
        if (meas_valid) begin
            q_per.push_back(int'(period));
            q_max.push_back(int'($signed(max_v)));
            q_min.push_back(int'($signed(min_v)));
            gap      = cyc - last_cyc;
            last_cyc = cyc;
            if (mv_d) wide++;
        end
        mv_d = meas_valid;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -2147483647;
    endfunction

    function automatic int tri_v(input int p, input int n);
        int q;
        q = n / 4;
        if (p <= q)     return p * STEP;
        if (p <= 3 * q) return (n / 2 - p) * STEP;
        return (p - n) * STEP;
    endfunction

    task automatic put(input int v, input bit vld);
        sample       = DW'(v + 8388608);
        sample_valid = vld;
        @(posedge clk);
        #1;
    endtask

    // Invalid cycles carry random garbage that must not disturb anything.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sample       = DW'($urandom);
            sample_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tone(input int n, input int p0, input int count, input int spacing, input bit noise);
        int p;
        int v;
        for (int i = 0; i < count; i++) begin
            p = (p0 + i) % n;
            v = tri_v(p, n);
            if (noise && (p >= n - 6 || p == 0 || (p >= 2 && p <= 5)))
                v = (p % 2 == 1) ? (HY - 1) : -(HY - 1);
            put(v, 1'b1);
            if (spacing > 1) idle(spacing - 1);
        end
    endtask

    task automatic clear_q();
        q_per.delete();
        q_max.delete();
        q_min.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", int'(period), 0);
        chk("rst_max", int'(max_v), 0);
        chk("rst_min", int'(min_v), 0);
        chk("rst_mv", int'(meas_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_nosig", int'(no_signal), 0);
        rst_n = 1'b1;
        idle(2);

        // Continuous 256-sample tone: crossings at 257, 513, 769, 1025.
        clear_q();
        tone(256, 0, 1026, 1, 1'b0);
        idle(1);
        chk("cont_count", q_per.size(), 3);
        chk("cont_period", pick(q_per, 2), 256);
        chk("cont_max", pick(q_max, 2), 262144);
        chk("cont_min", pick(q_min, 2), -262144);
        chk("cont_gap", gap, 256);
        chk("cont_locked", int'(locked), 1);
        chk("cont_nosig", int'(no_signal), 0);

        // One valid sample in four.
        clear_q();
        tone(256, 2, 768, 4, 1'b0);
        idle(1);
        chk("sparse_count", q_per.size(), 3);
        chk("sparse_period", pick(q_per, 2), 256);
        chk("sparse_gap", gap, 1024);
        chk("sparse_max", pick(q_max, 2), 262144);
        chk("sparse_min", pick(q_min, 2), -262144);

        // Sub-hysteresis chatter around each zero crossing.
        clear_q();
        tone(256, 2, 768, 1, 1'b1);
        idle(1);
        chk("noise_count", q_per.size(), 3);
        chk("noise_period", pick(q_per, 0), 256);
        chk("noise_period_last", pick(q_per, 2), 256);
        chk("noise_max", pick(q_max, 2), 262144);

        // Switch from 256 to 128 samples per period at a period boundary.
        clear_q();
        tone(256, 2, 254, 1, 1'b0);
        tone(128, 0, 386, 1, 1'b0);
        idle(1);
        chk("sw_count", q_per.size(), 4);
        chk("sw_period0", pick(q_per, 0), 256);
        chk("sw_period1", pick(q_per, 1), 128);
        chk("sw_period3", pick(q_per, 3), 128);
        chk("sw_max0", pick(q_max, 0), 262144);
        chk("sw_max3", pick(q_max, 3), 131072);
        chk("sw_min3", pick(q_min, 3), -131072);
        chk("wide_pulses", wide, 0);

        // Asynchronous reset mid-period while locked.
        tone(128, 2, 62, 1, 1'b0);
        chk("pre_rst_locked", int'(locked), 1);
        sample_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_max", int'(max_v), 0);
        chk("arst_min", int'(min_v), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_nosig", int'(no_signal), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        tone(128, 64, 192, 1, 1'b0);
        idle(1);
        chk("reacq_early", q_per.size(), 0);
        tone(128, 0, 2, 1, 1'b0);
        idle(1);
        chk("reacq_count", q_per.size(), 1);
        chk("reacq_period", pick(q_per, 0), 128);
        chk("reacq_max", pick(q_max, 0), 131072);
        chk("reacq_locked", int'(locked), 1);

        // Constant zero: timeout on the 65536th valid sample.
        clear_q();
        for (int i = 0; i < 65535; i++) put(0, 1'b1);
        idle(1);
        chk("to_before_nosig", int'(no_signal), 0);
        chk("to_before_locked", int'(locked), 1);
        put(0, 1'b1);
        idle(1);
        chk("to_nosig", int'(no_signal), 1);
        chk("to_locked", int'(locked), 0);
        chk("to_hold_period", int'(period), 128);
        chk("to_hold_max", int'($signed(max_v)), 131072);
        for (int i = 0; i < 4464; i++) put(0, 1'b1);
        idle(1);
        chk("to_still_nosig", int'(no_signal), 1);
        chk("to_no_pulses", q_per.size(), 0);

        // Recovery from no-signal.
        tone(256, 0, 514, 1, 1'b0);
        idle(1);
        chk("rec_count", q_per.size(), 1);
        chk("rec_period", pick(q_per, 0), 256);
        chk("rec_nosig", int'(no_signal), 0);
        chk("rec_locked", int'(locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
